// File: rtl/fifo_read_ctrl.sv
// Read-side drain controller: pulls a programmed burst from the async FIFO and streams it out via valid/ready.
// Optional pop statistics counter (rd_count) is enabled by defining FIFO_RD_STATS_EN.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_read,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   burst_len,
  input  logic                  empty_flag,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   remaining_reg;
  logic                  inflight_reg;
  logic [1:0]            occ_reg, occ_next;
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic                  pop;

  assign m_valid = (occ_reg != 2'd0);
  assign pop     = m_valid & m_ready;

  // Occupancy one cycle ahead: the read just issued lands next cycle, so it must fit then.
  assign occ_next = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};

  assign Read_enable = (state_reg == S_FETCH) & ~empty_flag &
                       (remaining_reg != '0) & (occ_next <= 2'd1);

  always_ff @(posedge clk_read or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      remaining_reg <= '0;
      inflight_reg  <= 1'b0;
      occ_reg       <= 2'd0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= Read_enable;
      occ_reg      <= occ_next;
      if (inflight_reg)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      if (state_reg == S_IDLE && start)
        remaining_reg <= burst_len;
      else if (Read_enable)
        remaining_reg <= remaining_reg - (ADDR_WIDTH+1)'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start)
          state_next = (burst_len != '0) ? S_FETCH : S_DONE;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (Read_enable && remaining_reg == (ADDR_WIDTH+1)'(1))
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!inflight_reg && occ_next == 2'd0)
          state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Two-entry skid buffer; entries reset to zero so m_data is 0 while in reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_reg;
      always_ff @(posedge clk_read or negedge rst) begin
        if (!rst)
          entry_reg <= '0;
        else if (inflight_reg && wr_ptr_reg == 1'(gi))
          entry_reg <= fifo_data;
      end
    end
  endgenerate

  assign m_data = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk_read or negedge rst) begin
    if (!rst)
      rd_count <= 16'd0;
    else if (pop && rd_count != 16'hFFFF)
      rd_count <= rd_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a small FIFO model feeds the DUT and a monitor records reads, pops and done.
// Define FIFO_RD_STATS_EN to also exercise rd_count.
module tb_fifo_read_ctrl;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk_read = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   burst_len;
  logic          empty_flag;
  logic [DW-1:0] fifo_data = '0;
  logic          Read_enable;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]   rd_count;
`endif

  always #5 clk_read = ~clk_read;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_read    (clk_read),
    .rst         (rst),
    .start       (start),
    .burst_len   (burst_len),
    .empty_flag  (empty_flag),
    .fifo_data   (fifo_data),
    .Read_enable (Read_enable),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
`ifdef FIFO_RD_STATS_EN
    .rd_count    (rd_count),
`endif
    .done        (done)
  );

  // FIFO model: one-cycle read latency, empty when drained or when forced.
  logic [DW-1:0] mem [256];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic          force_empty = 1'b0;
  assign empty_flag = force_empty || (wr_idx == rd_idx);

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int underflow = 0;
  int re_cyc_q[$];
  int out_q[$];
  int pop_cyc_q[$];

  always @(posedge clk_read) begin
    if (rst) begin
      if (Read_enable) begin
        re_cyc_q.push_back(cyc);
        if (empty_flag)
          underflow++;
        else begin
          fifo_data <= mem[rd_idx[7:0]];
          rd_idx    <= rd_idx + 1;
        end
      end
      if (m_valid && m_ready) begin
        out_q.push_back(int'(m_data));
        pop_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    cyc++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_seq(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_idx[7:0]] = DW'(base + i);
      wr_idx++;
    end
  endtask

  task automatic start_burst(input int len);
    @(negedge clk_read);
    burst_len = (AW+1)'(len);
    start     = 1'b1;
    @(negedge clk_read);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk_read);
      n++;
    end
    check(tag, int'(done_cnt != d0), 1);
  endtask

  // Checks that words base..base+n-1 arrived in order starting at out_q[o0].
  task automatic check_words(input string tag, input int o0, input int base, input int n);
    int bad = 0;
    check({tag, "_count"}, out_q.size() - o0, n);
    for (int i = 0; i < n && (o0 + i) < out_q.size(); i++)
      if (out_q[o0 + i] != base + i) bad++;
    check({tag, "_order"}, bad, 0);
  endtask

  task automatic scenario_full_burst(input string tag);
    int o0 = out_q.size();
    int r0 = re_cyc_q.size();
    int d0 = done_cnt;
    int gaps = 0;
    int re_gaps = 0;
    push_seq(0, 32);
    m_ready = 1'b1;
    start_burst(32);
    wait_done({tag, "_done"}, 200);
    repeat (3) @(negedge clk_read);
    check_words(tag, o0, 0, 32);
    for (int i = o0 + 1; i < pop_cyc_q.size(); i++)
      if (pop_cyc_q[i] - pop_cyc_q[i-1] != 1) gaps++;
    check({tag, "_bubbles"}, gaps, 0);
    check({tag, "_reads"}, re_cyc_q.size() - r0, 32);
    for (int i = r0 + 1; i < re_cyc_q.size(); i++)
      if (re_cyc_q[i] - re_cyc_q[i-1] != 1) re_gaps++;
    check({tag, "_read_gaps"}, re_gaps, 0);
    check({tag, "_fifo_empty"}, wr_idx - rd_idx, 0);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    $display("burst %s len=32 words=%0d reads=%0d", tag, out_q.size() - o0, re_cyc_q.size() - r0);
  endtask

  initial begin
    int o0, r0, d0, re_seen, busy_low;
    rst       = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    m_ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_read);
    #1;
    check("rst_re",    int'(Read_enable), 0);
    check("rst_valid", int'(m_valid), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
`ifdef FIFO_RD_STATS_EN
    check("rst_rd_count", int'(rd_count), 0);
`endif
    @(negedge clk_read);
    rst = 1'b1;

    // Asynchronous reset in the middle of a stalled burst
    push_seq(1, 2);
    start_burst(2);
    repeat (4) @(negedge clk_read);
    #1;
    check("t1_pre_valid", int'(m_valid), 1);
    check("t1_pre_data",  int'(m_data), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t1_async_re",    int'(Read_enable), 0);
    check("t1_async_valid", int'(m_valid), 0);
    check("t1_async_data",  int'(m_data), 0);
    check("t1_async_busy",  int'(busy), 0);
    check("t1_async_done",  int'(done), 0);
    @(negedge clk_read);
    rst = 1'b1;
    check("t1_fifo_drained", wr_idx - rd_idx, 0);
    $display("burst t1 len=2 interrupted by reset");

    // Two-word burst: back-to-back reads, done one cycle after last pop
    o0 = out_q.size();
    r0 = re_cyc_q.size();
    d0 = done_cnt;
    mem[wr_idx[7:0]] = 8'd8; wr_idx++;
    mem[wr_idx[7:0]] = 8'd9; wr_idx++;
    m_ready = 1'b1;
    start_burst(2);
    wait_done("t2_done", 50);
    repeat (3) @(negedge clk_read);
    check_words("t2", o0, 8, 2);
    check("t2_reads", re_cyc_q.size() - r0, 2);
    if (re_cyc_q.size() - r0 == 2)
      check("t2_reads_consecutive", re_cyc_q[r0+1] - re_cyc_q[r0], 1);
    if (pop_cyc_q.size() - o0 == 2) begin
      check("t2_pops_consecutive", pop_cyc_q[o0+1] - pop_cyc_q[o0], 1);
      check("t2_done_latency", done_cyc - pop_cyc_q[o0+1], 1);
    end
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_underflow", underflow, 0);
    $display("burst t2 len=2 words=%0d reads=%0d", out_q.size() - o0, re_cyc_q.size() - r0);

    // Full 32-word burst at one word per cycle
    scenario_full_burst("t3");

    // Downstream stall: only two reads issued, head held
    o0 = out_q.size();
    r0 = re_cyc_q.size();
    push_seq(0, 32);
    m_ready = 1'b0;
    start_burst(32);
    repeat (10) @(negedge clk_read);
    #1;
    check("t4_stall_reads", re_cyc_q.size() - r0, 2);
    check("t4_stall_re",    int'(Read_enable), 0);
    check("t4_stall_valid", int'(m_valid), 1);
    check("t4_stall_data",  int'(m_data), 0);
    m_ready = 1'b1;
    wait_done("t4_done", 200);
    repeat (2) @(negedge clk_read);
    check_words("t4", o0, 0, 32);
    check("t4_reads", re_cyc_q.size() - r0, 32);
    $display("burst t4 len=32 words=%0d reads=%0d", out_q.size() - o0, re_cyc_q.size() - r0);

    // Empty FIFO during FETCH: wait without reading, then complete
    o0 = out_q.size();
    r0 = re_cyc_q.size();
    force_empty = 1'b1;
    push_seq(100, 3);
    start_burst(3);
    re_seen  = 0;
    busy_low = 0;
    repeat (20) begin
      @(negedge clk_read);
      #1;
      if (Read_enable) re_seen++;
      if (!busy) busy_low++;
    end
    check("t5_empty_no_re",   re_seen, 0);
    check("t5_empty_busy",    busy_low, 0);
    check("t5_empty_reads",   re_cyc_q.size() - r0, 0);
    force_empty = 1'b0;
    wait_done("t5_done", 50);
    repeat (2) @(negedge clk_read);
    check_words("t5", o0, 100, 3);
    check("t5_underflow", underflow, 0);
    $display("burst t5 len=3 words=%0d reads=%0d", out_q.size() - o0, re_cyc_q.size() - r0);

    // Zero-length burst: done on the next cycle, no reads
    r0 = re_cyc_q.size();
    @(negedge clk_read);
    burst_len = '0;
    start     = 1'b1;
    @(negedge clk_read);
    start     = 1'b0;
    #1;
    check("t5_zero_done", int'(done), 1);
    check("t5_zero_busy", int'(busy), 0);
    @(negedge clk_read);
    #1;
    check("t5_zero_done_pulse", int'(done), 0);
    check("t5_zero_reads", re_cyc_q.size() - r0, 0);
    $display("burst t5 len=0 reads=%0d", re_cyc_q.size() - r0);

`ifdef FIFO_RD_STATS_EN
    // Pop counter: two full bursts after a reset, then cleared by reset
    @(negedge clk_read);
    rst = 1'b0;
    @(negedge clk_read);
    rst = 1'b1;
    check("t6_count_after_rst", int'(rd_count), 0);
    scenario_full_burst("t6a");
    scenario_full_burst("t6b");
    check("t6_count_64", int'(rd_count), 64);
    @(negedge clk_read);
    rst = 1'b0;
    #1;
    check("t6_count_cleared", int'(rd_count), 0);
    @(negedge clk_read);
    rst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
